// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU round-robin sequencer: FSM states, ALU opcodes and flag bit positions.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    localparam logic [1:0] OPER_SUB        = 2'b00;
    localparam logic [1:0] OPER_NAND       = 2'b01;
    localparam logic [1:0] OPER_START_ONES = 2'b10;
    localparam logic [1:0] OPER_DECODER    = 2'b11;

    localparam int unsigned FLAG_ERR      = 0;
    localparam int unsigned FLAG_NEG      = 1;
    localparam int unsigned FLAG_POS      = 2;
    localparam int unsigned FLAG_OVERFLOW = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: the pointer's requester wins a tie; the pointer moves to the loser after a grant.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant,
    output logic       next_ptr
);

    always_comb begin
        grant    = 2'b00;
        next_ptr = ptr;
        if (en) begin
            if (valid == 2'b11) begin
                grant = ptr ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
            if (grant[0]) begin
                next_ptr = 1'b1;
            end else if (grant[1]) begin
                next_ptr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALU between two requesters with round-robin grants and an id-tagged response channel.
// Optional grant statistics are built when ALU_SEQ_STATS_EN is defined.
module alu_rr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               s_CLK,
    input  logic               s_RSTn,
    input  logic [1:0]         i_req_valid,
    output logic [1:0]         o_req_ready,
    input  logic [2*WIDTH-1:0] i_req_a,
    input  logic [2*WIDTH-1:0] i_req_b,
    input  logic [3:0]         i_req_oper,
    output logic [WIDTH-1:0]   o_alu_arg0,
    output logic [WIDTH-1:0]   o_alu_arg1,
    output logic [1:0]         o_alu_oper,
    input  logic [WIDTH-1:0]   i_alu_result,
    input  logic [3:0]         i_alu_flag,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic               o_rsp_id,
    output logic [WIDTH-1:0]   o_rsp_result,
    output logic [3:0]         o_rsp_flag,
    output logic               o_busy,
    output logic [2*CNT_W-1:0] o_grant_cnt
);

    seq_state_e       state_q, state_d;
    logic             ptr_q;
    logic             next_ptr;
    logic [1:0]       grant;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       oper_q;
    logic             id_q;
    logic [2:0]       cnt_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_flag_q;

    // Gating with the reset keeps ready low while reset is held, not just after it.
    rr_arb2 u_arb (
        .valid    (i_req_valid),
        .ptr      (ptr_q),
        .en       ((state_q == IDLE) && !s_RSTn),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    assign accept      = |grant;
    assign sel         = grant[1];
    assign o_req_ready = grant;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (cnt_q == 3'd0) state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_alu_arg0 = '0;
        o_alu_arg1 = '0;
        o_alu_oper = '0;
        if (state_q == EXEC) begin
            o_alu_arg0 = a_q;
            o_alu_arg1 = b_q;
            o_alu_oper = oper_q;
        end
    end

    assign o_busy       = (state_q != IDLE);
    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_flag   = rsp_flag_q;

    always_ff @(posedge s_CLK or posedge s_RSTn) begin
        if (s_RSTn) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            oper_q       <= OPER_SUB;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q  <= next_ptr;
                a_q    <= sel ? i_req_a[2*WIDTH-1:WIDTH] : i_req_a[WIDTH-1:0];
                b_q    <= sel ? i_req_b[2*WIDTH-1:WIDTH] : i_req_b[WIDTH-1:0];
                oper_q <= sel ? i_req_oper[3:2] : i_req_oper[1:0];
                id_q   <= sel;
                // EXEC lasts ALU_LAT cycles, so the count starts one below the latency.
                cnt_q  <= 3'(ALU_LAT - 1);
            end
            if (state_q == EXEC) begin
                if (cnt_q == 3'd0) begin
                    rsp_id_q     <= id_q;
                    rsp_result_q <= i_alu_result;
                    rsp_flag_q   <= i_alu_flag;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [1:0][CNT_W-1:0] grant_cnt_q;

    always_ff @(posedge s_CLK or posedge s_RSTn) begin
        if (s_RSTn) begin
            grant_cnt_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (grant[k] && (grant_cnt_q[k] != {CNT_W{1'b1}})) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign o_grant_cnt = grant_cnt_q;
`else
    assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_rr_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned ALU_LAT = 1;
    localparam int unsigned CNT_W   = 2;

    logic               s_CLK = 1'b0;
    logic               s_RSTn = 1'b1;
    logic [1:0]         req_valid = '0;
    logic [1:0]         o_req_ready;
    logic [2*WIDTH-1:0] req_a = '0;
    logic [2*WIDTH-1:0] req_b = '0;
    logic [3:0]         req_oper = '0;
    logic [WIDTH-1:0]   o_alu_arg0, o_alu_arg1;
    logic [1:0]         o_alu_oper;
    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flag;
    logic               o_rsp_valid;
    logic               rsp_ready = 1'b0;
    logic               o_rsp_id;
    logic [WIDTH-1:0]   o_rsp_result;
    logic [3:0]         o_rsp_flag;
    logic               o_busy;
    logic [2*CNT_W-1:0] o_grant_cnt;

    typedef struct {
        logic       id;
        logic [3:0] result;
        logic [3:0] flag;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 s_CLK = ~s_CLK;
    always @(posedge s_CLK) cyc++;

    alu_rr_sequencer #(
        .WIDTH   (WIDTH),
        .ALU_LAT (ALU_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .s_CLK        (s_CLK),
        .s_RSTn       (s_RSTn),
        .i_req_valid  (req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_oper   (req_oper),
        .o_alu_arg0   (o_alu_arg0),
        .o_alu_arg1   (o_alu_arg1),
        .o_alu_oper   (o_alu_oper),
        .i_alu_result (alu_result),
        .i_alu_flag   (alu_flag),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_result (o_rsp_result),
        .o_rsp_flag   (o_rsp_flag),
        .o_busy       (o_busy),
        .o_grant_cnt  (o_grant_cnt)
    );

    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] op);
        logic [3:0] r;
        logic [3:0] f;
        logic       run;
        r = '0;
        f = '0;
        case (op)
            OPER_SUB: begin
                r = a - b;
                f[FLAG_OVERFLOW] = (a[3] != b[3]) && (r[3] != a[3]);
            end
            OPER_NAND: r = ~(a & b);
            OPER_START_ONES: begin
                run = 1'b1;
                for (int i = 3; i >= 0; i--) begin
                    if (!a[i]) run = 1'b0;
                    if (run) r = r + 4'd1;
                end
            end
            default: begin
                if (a >= 4'd4) f[FLAG_ERR] = 1'b1;
                else r = 4'b0001 << a[1:0];
            end
        endcase
        f[FLAG_NEG] = r[3];
        f[FLAG_POS] = !r[3] && (r != 4'd0);
        return {f, r};
    endfunction

    assign {alu_flag, alu_result} = alu_model(o_alu_arg0, o_alu_arg1, o_alu_oper);

    // Scoreboard: push at request handshake, pop and compare at response handshake.
    always @(negedge s_CLK) begin
        if (!s_RSTn) begin
            if (o_req_ready != 2'b00) begin
                checks++;
                if (((o_req_ready & ~req_valid) != 2'b00) || (o_req_ready == 2'b11)) begin
                    errors++;
                    $display("FAIL ready_onehot: ready=%b valid=%b", o_req_ready, req_valid);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (req_valid[k] && o_req_ready[k]) begin
                    exp_t e;
                    logic [7:0] m;
                    m = alu_model(req_a[k*4 +: 4], req_b[k*4 +: 4], req_oper[k*2 +: 2]);
                    e.id = k[0];
                    e.flag = m[7:4];
                    e.result = m[3:0];
                    sb.push_back(e);
                    grant_log.push_back(k);
                end
            end
            if (o_rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got id=%0d result=%h, expected none",
                             o_rsp_id, o_rsp_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (o_rsp_id !== e.id || o_rsp_result !== e.result || o_rsp_flag !== e.flag) begin
                        errors++;
                        $display("FAIL rsp_data: got id=%0d result=%h flag=%b, expected id=%0d result=%h flag=%b",
                                 o_rsp_id, o_rsp_result, o_rsp_flag, e.id, e.result, e.flag);
                    end
                end
            end
        end
    end

    task automatic set_req(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op);
        req_a[k*4 +: 4]    = a;
        req_b[k*4 +: 4]    = b;
        req_oper[k*2 +: 2] = op;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge s_CLK);
            if (o_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge s_CLK);
            if (sb.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge s_CLK);
        #2;
        req_valid = '0;
        s_RSTn = 1'b1;
        sb.delete();
        grant_log.delete();
        @(negedge s_CLK);
        s_RSTn = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        req_valid = 2'b11;
        s_RSTn = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", o_req_ready);
        end
        checks++;
        if ({o_rsp_valid, o_busy, o_rsp_id} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000", {o_rsp_valid, o_busy, o_rsp_id});
        end
        checks++;
        if ({o_alu_arg0, o_alu_arg1, o_alu_oper} !== 10'd0) begin
            errors++; $display("FAIL reset_alu: got %h expected 0", {o_alu_arg0, o_alu_arg1, o_alu_oper});
        end
        checks++;
        if ({o_rsp_result, o_rsp_flag, o_grant_cnt} !== 12'd0) begin
            errors++; $display("FAIL reset_rsp: got %h expected 0", {o_rsp_result, o_rsp_flag, o_grant_cnt});
        end
        @(negedge s_CLK);
        req_valid = 2'b00;
        s_RSTn = 1'b0;
        drain(ok);
    endtask

    task automatic test_single();
        bit ok;
        int n;
        @(posedge s_CLK); #1;
        rsp_ready = 1'b1;
        set_req(0, 4'b0101, 4'b0011, OPER_SUB);
        req_valid = 2'b01;
        @(negedge s_CLK);
        n = cyc;
        checks++;
        if (o_req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready: got %b expected 01", o_req_ready);
        end
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        set_req(0, 4'hF, 4'hF, 2'b11);
        @(negedge s_CLK);
        checks++;
        if ({o_busy, o_rsp_valid, o_alu_arg0, o_alu_arg1, o_alu_oper} !== {2'b10, 4'b0101, 4'b0011, 2'b00}) begin
            errors++;
            $display("FAIL single_exec: got busy=%b rv=%b a0=%b a1=%b op=%b expected 1 0 0101 0011 00",
                     o_busy, o_rsp_valid, o_alu_arg0, o_alu_arg1, o_alu_oper);
        end
        wait_rsp(ok);
        checks++;
        if (!ok || cyc != n + 2) begin
            errors++; $display("FAIL single_latency: got cycle %0d expected %0d (seen=%0d)", cyc, n + 2, ok);
        end
        checks++;
        if ({o_rsp_id, o_rsp_result, o_rsp_flag[FLAG_POS]} !== {1'b0, 4'b0010, 1'b1}) begin
            errors++; $display("FAIL single_rsp: got id=%0d result=%b pos=%b expected 0 0010 1",
                               o_rsp_id, o_rsp_result, o_rsp_flag[FLAG_POS]);
        end
        @(negedge s_CLK);
        checks++;
        if (o_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drop: got rsp_valid=%b expected 0", o_rsp_valid);
        end
        drain(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL single_drain: got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_alternate();
        bit ok;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge s_CLK); #1;
            req_valid = 2'b11;
            req_a = 8'($urandom);
            req_b = 8'($urandom);
            req_oper = 4'($urandom);
        end
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        drain(ok);
        checks++;
        if (!ok || grant_log.size() < 6) begin
            errors++; $display("FAIL alt_count: got %0d grants expected at least 6", grant_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (grant_log[i] != i % 2) begin
                    errors++; $display("FAIL alt_order: grant %0d got %0d expected %0d", i, grant_log[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        rsp_ready = 1'b0;
        @(posedge s_CLK); #1;
        set_req(1, 4'b1111, 4'b0000, OPER_NAND);
        req_valid = 2'b10;
        @(negedge s_CLK);
        checks++;
        if (o_req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_ready: got %b expected 10", o_req_ready);
        end
        @(posedge s_CLK); #1;
        set_req(1, 4'h0, 4'h0, 2'b00);
        set_req(0, 4'b0011, 4'b0001, OPER_SUB);
        req_valid = 2'b01;
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_rsp: got no response expected rsp_valid");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge s_CLK);
            checks++;
            if ({o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready} !== {2'b11, 4'b1111, 2'b00}) begin
                errors++; $display("FAIL bp_stall: got rv=%b id=%0d result=%b ready=%b expected 1 1 1111 00",
                                   o_rsp_valid, o_rsp_id, o_rsp_result, o_req_ready);
            end
        end
        @(posedge s_CLK); #1;
        rsp_ready = 1'b1;
        @(negedge s_CLK);
        @(negedge s_CLK);
        checks++;
        if (o_req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_next_grant: got %b expected 01", o_req_ready);
        end
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_drain: got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_drop();
        bit ok;
        logic [1:0] seen;
        do_reset();
        rsp_ready = 1'b0;
        @(posedge s_CLK); #1;
        set_req(0, 4'b0110, 4'b0010, OPER_START_ONES);
        req_valid = 2'b01;
        @(negedge s_CLK);
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        @(posedge s_CLK); #1;
        req_valid = 2'b01;
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge s_CLK);
        #1;
        rsp_ready = 1'b1;
        seen = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge s_CLK);
            seen = seen | o_req_ready;
        end
        checks++;
        if (seen !== 2'b00 || grant_log.size() != 1) begin
            errors++; $display("FAIL drop_no_grant: got ready=%b grants=%0d expected 00 1",
                               seen, grant_log.size());
        end
        @(posedge s_CLK); #1;
        set_req(0, 4'b1100, 4'b0000, OPER_START_ONES);
        set_req(1, 4'b0010, 4'b0000, OPER_DECODER);
        req_valid = 2'b11;
        @(negedge s_CLK);
        checks++;
        if (o_req_ready !== 2'b10) begin
            errors++; $display("FAIL drop_ptr: got %b expected 10", o_req_ready);
        end
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        drain(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_ready = 1'b1;
        @(posedge s_CLK); #1;
        set_req(0, 4'b0111, 4'b0110, OPER_SUB);
        req_valid = 2'b01;
        @(negedge s_CLK);
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        #1;
        checks++;
        if ({o_busy, o_alu_arg0} !== {1'b1, 4'b0111}) begin
            errors++; $display("FAIL mid_exec: got busy=%b a0=%b expected 1 0111", o_busy, o_alu_arg0);
        end
        s_RSTn = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_rsp_valid, o_req_ready, o_alu_arg0, o_alu_arg1, o_alu_oper} !== 14'd0) begin
            errors++; $display("FAIL mid_reset: got busy=%b rv=%b ready=%b a0=%h a1=%h op=%b expected all 0",
                               o_busy, o_rsp_valid, o_req_ready, o_alu_arg0, o_alu_arg1, o_alu_oper);
        end
        sb.delete();
        grant_log.delete();
        @(negedge s_CLK);
        s_RSTn = 1'b0;
        @(posedge s_CLK); #1;
        set_req(1, 4'b1000, 4'b0001, OPER_SUB);
        req_valid = 2'b11;
        @(negedge s_CLK);
        checks++;
        if (o_req_ready !== 2'b01) begin
            errors++; $display("FAIL mid_ptr: got %b expected 01", o_req_ready);
        end
        @(posedge s_CLK); #1;
        req_valid = 2'b00;
        drain(ok);
    endtask

    task automatic test_stats();
        bit ok;
        logic [CNT_W-1:0] exp0;
`ifdef ALU_SEQ_STATS_EN
        exp0 = 2'd3;
`else
        exp0 = 2'd0;
`endif
        do_reset();
        rsp_ready = 1'b1;
        @(posedge s_CLK); #1;
        set_req(0, 4'b0001, 4'b0010, OPER_SUB);
        req_valid = 2'b01;
        for (int i = 0; i < 40; i++) begin
            @(posedge s_CLK); #1;
            if (grant_log.size() >= 5) break;
        end
        req_valid = 2'b00;
        drain(ok);
        checks++;
        if (grant_log.size() != 5) begin
            errors++; $display("FAIL stats_grants: got %0d expected 5", grant_log.size());
        end
        checks++;
        if (o_grant_cnt !== {2'd0, exp0}) begin
            errors++; $display("FAIL stats_cnt: got %h expected %h", o_grant_cnt, {2'd0, exp0});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
